// File: rtl/bloom_filter_csr_ctrl.sv
// Avalon-MM CSR master for the bloom filter: runs LUT clean + enable bring-up,
// then periodically sweeps the clear-on-read match counters into saturating totals.

module bloom_filter_csr_ctrl_acc #(
    parameter int DATA_W  = 32,
    parameter int TOTAL_W = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_clr,
    input  logic               i_add,
    input  logic [DATA_W-1:0]  i_data,
    output logic [TOTAL_W-1:0] o_total
);
    localparam int SUM_W = TOTAL_W + 1;

    logic [TOTAL_W-1:0] r_total;
    logic [TOTAL_W:0]   w_sum;

    // One guard bit catches the carry out; any carry means the total is pinned at max.
    assign w_sum = {1'b0, r_total} + SUM_W'(i_data);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      r_total <= '0;
        else if (i_clr) r_total <= '0;
        else if (i_add) r_total <= w_sum[TOTAL_W] ? '1 : w_sum[TOTAL_W-1:0];
    end

    assign o_total = r_total;
endmodule

module bloom_filter_csr_ctrl #(
    parameter int AMM_CSR_ADDR_W      = 8,
    parameter int AMM_CSR_DATA_W      = 32,
    parameter int MATCH_CNT_CNT       = 4,
    parameter int EN_ADDR             = 0,
    parameter int HASH_LUT_CLEAN_ADDR = 1,
    parameter int MATCH_CNT_BASE      = 2,
    parameter int POLL_PERIOD         = 1024,
    parameter int CLEAN_TIMEOUT       = 4096,
    parameter int TOTAL_W             = 64
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   start_i,
    input  logic                                   stop_i,
    output logic [AMM_CSR_ADDR_W-1:0]              amm_master_csr_address_o,
    output logic                                   amm_master_csr_read_o,
    input  logic [AMM_CSR_DATA_W-1:0]              amm_master_csr_readdata_i,
    output logic                                   amm_master_csr_write_o,
    output logic [AMM_CSR_DATA_W-1:0]              amm_master_csr_writedata_o,
    output logic                                   busy_o,
    output logic                                   running_o,
    output logic                                   error_o,
    output logic [MATCH_CNT_CNT-1:0][TOTAL_W-1:0]  totals_o,
    output logic                                   totals_valid_o
);
    localparam int TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD + 1) : 1;
    localparam int CNT_W = $clog2(CLEAN_TIMEOUT + 1);
    localparam int IDX_W = (MATCH_CNT_CNT > 1) ? $clog2(MATCH_CNT_CNT) : 1;

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(POLL_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLEAN_TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MATCH_CNT_CNT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR_WR, S_CLR_RD, S_CLR_CHK, S_EN_WR,
        S_RUN, S_ST_RD, S_ST_CAP, S_DIS_WR
    } state_t;

    state_t             r_state, w_next;
    logic [TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_stop_pend;
    logic               r_running;
    logic               r_error;
    logic               r_totals_valid;

    logic               w_start;
    logic               w_clean_busy;
    logic               w_cap;
    logic [MATCH_CNT_CNT-1:0] w_add;

    assign w_start      = (r_state == S_IDLE) && start_i;
    assign w_clean_busy = amm_master_csr_readdata_i[0];
    assign w_cap        = (r_state == S_ST_CAP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start_i) w_next = S_CLR_WR;
            S_CLR_WR:  w_next = S_CLR_RD;
            S_CLR_RD:  w_next = S_CLR_CHK;
            S_CLR_CHK: begin
                if (!w_clean_busy)         w_next = S_EN_WR;
                else if (r_cnt >= CNT_MAX) w_next = S_IDLE;
                else                       w_next = S_CLR_RD;
            end
            S_EN_WR:   w_next = S_RUN;
            // A pending stop is only honoured here, so a sweep never loses a counter.
            S_RUN: begin
                if (r_stop_pend)        w_next = S_DIS_WR;
                else if (r_timer == '0) w_next = S_ST_RD;
            end
            S_ST_RD:   w_next = S_ST_CAP;
            S_ST_CAP:  w_next = (r_idx == IDX_LAST) ? S_RUN : S_ST_RD;
            S_DIS_WR:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        amm_master_csr_address_o   = '0;
        amm_master_csr_read_o      = 1'b0;
        amm_master_csr_write_o     = 1'b0;
        amm_master_csr_writedata_o = '0;
        case (r_state)
            S_CLR_WR: begin
                amm_master_csr_address_o   = AMM_CSR_ADDR_W'(HASH_LUT_CLEAN_ADDR);
                amm_master_csr_write_o     = 1'b1;
                amm_master_csr_writedata_o = AMM_CSR_DATA_W'(1);
            end
            S_CLR_RD: begin
                amm_master_csr_address_o = AMM_CSR_ADDR_W'(HASH_LUT_CLEAN_ADDR);
                amm_master_csr_read_o    = 1'b1;
            end
            S_EN_WR: begin
                amm_master_csr_address_o   = AMM_CSR_ADDR_W'(EN_ADDR);
                amm_master_csr_write_o     = 1'b1;
                amm_master_csr_writedata_o = AMM_CSR_DATA_W'(1);
            end
            S_ST_RD: begin
                amm_master_csr_address_o = AMM_CSR_ADDR_W'(MATCH_CNT_BASE) + AMM_CSR_ADDR_W'(r_idx);
                amm_master_csr_read_o    = 1'b1;
            end
            S_DIS_WR: begin
                amm_master_csr_address_o = AMM_CSR_ADDR_W'(EN_ADDR);
                amm_master_csr_write_o   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timer        <= '0;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_stop_pend    <= 1'b0;
            r_running      <= 1'b0;
            r_error        <= 1'b0;
            r_totals_valid <= 1'b0;
        end else begin
            r_totals_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_stop_pend <= 1'b0;
                    if (start_i) begin
                        r_error <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_CLR_RD:  r_cnt <= r_cnt + CNT_W'(1);
                S_CLR_CHK: if (w_clean_busy && (r_cnt >= CNT_MAX)) r_error <= 1'b1;
                S_EN_WR: begin
                    r_running <= 1'b1;
                    r_timer   <= TMR_LOAD;
                end
                S_RUN: begin
                    if (r_timer != '0) r_timer <= r_timer - TMR_W'(1);
                    r_idx <= '0;
                end
                S_ST_CAP: begin
                    if (r_idx == IDX_LAST) begin
                        r_totals_valid <= 1'b1;
                        r_timer        <= TMR_LOAD;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DIS_WR: begin
                    r_running   <= 1'b0;
                    r_stop_pend <= 1'b0;
                end
                default: ;
            endcase
            if (stop_i && (r_state != S_IDLE) && (r_state != S_DIS_WR))
                r_stop_pend <= 1'b1;
        end
    end

    for (genvar g = 0; g < MATCH_CNT_CNT; g++) begin : g_acc
        assign w_add[g] = w_cap && (r_idx == IDX_W'(g));

        bloom_filter_csr_ctrl_acc #(
            .DATA_W  (AMM_CSR_DATA_W),
            .TOTAL_W (TOTAL_W)
        ) u_acc (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .i_clr   (w_start),
            .i_add   (w_add[g]),
            .i_data  (amm_master_csr_readdata_i),
            .o_total (totals_o[g])
        );
    end

    assign busy_o         = (r_state != S_IDLE);
    assign running_o      = r_running;
    assign error_o        = r_error;
    assign totals_valid_o = r_totals_valid;
endmodule

// File: tb/tb_bloom_filter_csr_ctrl.sv
// Directed bench for bloom_filter_csr_ctrl: behavioural CSR slave, bus monitor log,
// and per-scenario tasks checking exact bus cycles and totals.

module tb_bloom_filter_csr_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NC = 4;
    localparam int TW = 33;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic                   stop = 1'b0;
    logic [AW-1:0]          addr;
    logic                   rd, wr;
    logic [DW-1:0]          rdata = '0;
    logic [DW-1:0]          wdata;
    logic                   busy, running, error, tvalid;
    logic [NC-1:0][TW-1:0]  totals;

    int checks = 0;
    int errors = 0;

    bloom_filter_csr_ctrl #(
        .AMM_CSR_ADDR_W (AW), .AMM_CSR_DATA_W (DW), .MATCH_CNT_CNT (NC),
        .EN_ADDR (0), .HASH_LUT_CLEAN_ADDR (1), .MATCH_CNT_BASE (2),
        .POLL_PERIOD (8), .CLEAN_TIMEOUT (3), .TOTAL_W (TW)
    ) dut (
        .clk_i (clk), .rst_i (rst), .start_i (start), .stop_i (stop),
        .amm_master_csr_address_o (addr), .amm_master_csr_read_o (rd),
        .amm_master_csr_readdata_i (rdata), .amm_master_csr_write_o (wr),
        .amm_master_csr_writedata_o (wdata), .busy_o (busy), .running_o (running),
        .error_o (error), .totals_o (totals), .totals_valid_o (tvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: one-cycle read latency, garbage when no read was issued.
    logic [DW-1:0] cnt_val [NC];
    bit            clean_q [$];
    always @(posedge clk) begin
        if (rd) begin
            if (addr == 8'd1) begin
                if (clean_q.size() > 0) rdata <= DW'(clean_q.pop_front());
                else                    rdata <= 32'd1;
            end else if (addr >= 8'd2 && addr < 8'd6) begin
                rdata <= cnt_val[addr - 8'd2];
            end else begin
                rdata <= '0;
            end
        end else begin
            rdata <= 32'hDEADBEEF;
        end
    end

    typedef struct {
        int          c;
        bit          w;
        int          a;
        longint      d;
    } txn_t;
    txn_t log_q [$];
    txn_t mon_t;
    int   viol = 0;
    int   vcnt = 0;

    always @(negedge clk) begin
        if (rd || wr) begin
            mon_t.c = cyc;
            mon_t.w = wr;
            mon_t.a = int'(addr);
            mon_t.d = longint'(wdata);
            log_q.push_back(mon_t);
        end
        if (rd && wr) viol++;
        if (!rd && !wr && (addr != '0 || wdata != '0)) viol++;
        if (rd && wdata != '0) viol++;
        if (tvalid) vcnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick_to(input int c);
        forever begin
            @(negedge clk);
            #1;
            if (cyc >= c) break;
        end
    endtask

    task automatic pulse_start(output int t);
        @(posedge clk); #1;
        start = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    int t0, t1, t2, t3;

    task automatic test_reset();
        int base;
        tick_to(1);
        checks++;
        if ({rd, wr, addr, wdata} !== '0) begin
            errors++; $display("FAIL reset_bus got %h exp 0", {rd, wr, addr, wdata});
        end
        checks++;
        if ({busy, running, error, tvalid} !== 4'b0) begin
            errors++; $display("FAIL reset_status got %b exp 0000", {busy, running, error, tvalid});
        end
        checks++;
        if (totals !== '0) begin
            errors++; $display("FAIL reset_totals got %h exp 0", totals);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        base = log_q.size();
        tick_to(cyc + 10);
        checks++;
        if (log_q.size() - base !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_quiet got %0d txns busy %b exp 0 txns busy 0", log_q.size() - base, busy);
        end
    endtask

    task automatic test_bringup();
        int  base, n;
        int  ec [5] = '{1, 2, 4, 6, 8};
        bit  ew [5] = '{1, 0, 0, 0, 1};
        int  ea [5] = '{1, 1, 1, 1, 0};
        int  ed [5] = '{1, 0, 0, 0, 1};
        clean_q = '{1, 1, 0};
        cnt_val = '{32'd5, 32'd0, 32'd7, 32'd3};
        base = log_q.size();
        pulse_start(t0);
        tick_to(t0 + 8);
        checks++;
        if (running !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL bringup_en_cycle running %b busy %b exp 0 1", running, busy);
        end
        tick_to(t0 + 9);
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL bringup_running got %b exp 1", running);
        end
        n = log_q.size() - base;
        checks++;
        if (n !== 5) begin
            errors++; $display("FAIL bringup_txn_count got %0d exp 5", n);
        end
        for (int i = 0; i < 5 && i < n; i++) begin
            txn_t e = log_q[base + i];
            checks++;
            if (e.c - t0 !== ec[i] || e.w !== ew[i] || e.a !== ea[i] || e.d !== longint'(ed[i])) begin
                errors++;
                $display("FAIL bringup_txn%0d got cyc %0d wr %0d a %0d d %0d exp cyc %0d wr %0d a %0d d %0d",
                         i, e.c - t0, e.w, e.a, e.d, ec[i], ew[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_sweep();
        int base, n, v0;
        logic [NC-1:0][TW-1:0] exp_t;
        base = log_q.size();
        v0 = vcnt;
        tick_to(t0 + 25);
        exp_t[0] = 5; exp_t[1] = 0; exp_t[2] = 7; exp_t[3] = 3;
        checks++;
        if (tvalid !== 1'b1 || totals !== exp_t) begin
            errors++; $display("FAIL sweep1 totals got %h valid %b exp %h valid 1", totals, tvalid, exp_t);
        end
        n = log_q.size() - base;
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL sweep1_txn_count got %0d exp 4", n);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            txn_t e = log_q[base + i];
            checks++;
            if (e.c - t0 !== 17 + 2 * i || e.w !== 1'b0 || e.a !== 2 + i) begin
                errors++;
                $display("FAIL sweep1_rd%0d got cyc %0d wr %0d a %0d exp cyc %0d wr 0 a %0d",
                         i, e.c - t0, e.w, e.a, 17 + 2 * i, 2 + i);
            end
        end
        cnt_val = '{32'd1, 32'd1, 32'd1, 32'd1};
        base = log_q.size();
        tick_to(t0 + 41);
        exp_t[0] = 6; exp_t[1] = 1; exp_t[2] = 8; exp_t[3] = 4;
        checks++;
        if (tvalid !== 1'b1 || totals !== exp_t) begin
            errors++; $display("FAIL sweep2 totals got %h valid %b exp %h valid 1", totals, tvalid, exp_t);
        end
        checks++;
        if (vcnt - v0 !== 2) begin
            errors++; $display("FAIL sweep_valid_pulses got %0d exp 2", vcnt - v0);
        end
        n = log_q.size() - base;
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL sweep2_txn_count got %0d exp 4", n);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            txn_t e = log_q[base + i];
            checks++;
            if (e.c - t0 !== 33 + 2 * i || e.w !== 1'b0 || e.a !== 2 + i) begin
                errors++;
                $display("FAIL sweep2_rd%0d got cyc %0d a %0d exp cyc %0d a %0d",
                         i, e.c - t0, e.a, 33 + 2 * i, 2 + i);
            end
        end
    endtask

    task automatic test_stop_mid_sweep();
        int base, n;
        int ec [5] = '{49, 51, 53, 55, 58};
        int ea [5] = '{2, 3, 4, 5, 0};
        bit ew [5] = '{0, 0, 0, 0, 1};
        logic [NC-1:0][TW-1:0] exp_t;
        base = log_q.size();
        tick_to(t0 + 50);
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        tick_to(t0 + 57);
        exp_t[0] = 7; exp_t[1] = 2; exp_t[2] = 9; exp_t[3] = 5;
        checks++;
        if (tvalid !== 1'b1 || totals !== exp_t) begin
            errors++; $display("FAIL stop_sweep_totals got %h valid %b exp %h valid 1", totals, tvalid, exp_t);
        end
        tick_to(t0 + 58);
        checks++;
        if (busy !== 1'b1 || running !== 1'b1 || wr !== 1'b1 || addr !== 8'd0 || wdata !== 32'd0) begin
            errors++; $display("FAIL stop_dis_wr busy %b run %b wr %b a %0d d %0d exp 1 1 1 0 0", busy, running, wr, addr, wdata);
        end
        tick_to(t0 + 59);
        checks++;
        if (busy !== 1'b0 || running !== 1'b0) begin
            errors++; $display("FAIL stop_idle busy %b running %b exp 0 0", busy, running);
        end
        tick_to(t0 + 65);
        n = log_q.size() - base;
        checks++;
        if (n !== 5) begin
            errors++; $display("FAIL stop_txn_count got %0d exp 5", n);
        end
        for (int i = 0; i < 5 && i < n; i++) begin
            txn_t e = log_q[base + i];
            checks++;
            if (e.c - t0 !== ec[i] || e.w !== ew[i] || e.a !== ea[i] || e.d !== 64'd0) begin
                errors++;
                $display("FAIL stop_txn%0d got cyc %0d wr %0d a %0d d %0d exp cyc %0d wr %0d a %0d d 0",
                         i, e.c - t0, e.w, e.a, e.d, ec[i], ew[i], ea[i]);
            end
        end
    endtask

    task automatic test_clean_timeout();
        int base, n;
        int ec [4] = '{1, 2, 4, 6};
        bit ew [4] = '{1, 0, 0, 0};
        clean_q.delete();
        base = log_q.size();
        pulse_start(t1);
        tick_to(t1 + 7);
        checks++;
        if (busy !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL timeout_pre busy %b error %b exp 1 0", busy, error);
        end
        tick_to(t1 + 8);
        checks++;
        if (busy !== 1'b0 || error !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL timeout_flag busy %b error %b running %b exp 0 1 0", busy, error, running);
        end
        tick_to(t1 + 20);
        checks++;
        if (error !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky got %b exp 1", error);
        end
        n = log_q.size() - base;
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL timeout_txn_count got %0d exp 4", n);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            txn_t e = log_q[base + i];
            checks++;
            if (e.c - t1 !== ec[i] || e.w !== ew[i] || e.a !== 1) begin
                errors++;
                $display("FAIL timeout_txn%0d got cyc %0d wr %0d a %0d exp cyc %0d wr %0d a 1",
                         i, e.c - t1, e.w, e.a, ec[i], ew[i]);
            end
        end
    endtask

    task automatic test_restart_and_early_stop();
        int base, n;
        int ec [4] = '{1, 2, 4, 8};
        bit ew [4] = '{1, 0, 1, 1};
        int ea [4] = '{1, 1, 0, 0};
        int ed [4] = '{1, 0, 1, 0};
        clean_q.push_back(1'b0);
        base = log_q.size();
        pulse_start(t2);
        tick_to(t2 + 1);
        checks++;
        if (error !== 1'b0 || totals !== '0) begin
            errors++; $display("FAIL restart_clear error %b totals %h exp 0 0", error, totals);
        end
        tick_to(t2 + 4);
        checks++;
        if (wr !== 1'b1 || addr !== 8'd0 || wdata !== 32'd1 || running !== 1'b0) begin
            errors++; $display("FAIL restart_en_wr wr %b a %0d d %0d run %b exp 1 0 1 0", wr, addr, wdata, running);
        end
        tick_to(t2 + 5);
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL restart_running got %b exp 1", running);
        end
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        tick_to(t2 + 9);
        checks++;
        if (busy !== 1'b0 || running !== 1'b0) begin
            errors++; $display("FAIL early_stop_idle busy %b running %b exp 0 0", busy, running);
        end
        n = log_q.size() - base;
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL early_stop_txn_count got %0d exp 4", n);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            txn_t e = log_q[base + i];
            checks++;
            if (e.c - t2 !== ec[i] || e.w !== ew[i] || e.a !== ea[i] || e.d !== longint'(ed[i])) begin
                errors++;
                $display("FAIL early_stop_txn%0d got cyc %0d wr %0d a %0d d %0d exp cyc %0d wr %0d a %0d d %0d",
                         i, e.c - t2, e.w, e.a, e.d, ec[i], ew[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [TW-1:0] exp_s [3] = '{33'h0FFFFFFFF, 33'h1FFFFFFFE, 33'h1FFFFFFFF};
        int            vc [3] = '{21, 37, 53};
        clean_q.push_back(1'b0);
        cnt_val = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        // start and stop together in IDLE: the stop must be dropped
        @(posedge clk); #1;
        start = 1'b1;
        stop  = 1'b1;
        t3 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        tick_to(t3 + 9);
        checks++;
        if (running !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL start_stop_same_cycle running %b busy %b exp 1 1", running, busy);
        end
        for (int k = 0; k < 3; k++) begin
            tick_to(t3 + vc[k]);
            for (int j = 0; j < NC; j++) begin
                checks++;
                if (tvalid !== 1'b1 || totals[j] !== exp_s[k]) begin
                    errors++;
                    $display("FAIL sat_sweep%0d_total%0d got %h valid %b exp %h valid 1",
                             k, j, totals[j], tvalid, exp_s[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        tick_to(t3 + 61);
        checks++;
        if (rd !== 1'b1 || addr !== 8'd2) begin
            errors++; $display("FAIL midrst_pre rd %b a %0d exp 1 2", rd, addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rd, wr, addr, wdata} !== '0 || busy !== 1'b0 || running !== 1'b0 || totals !== '0) begin
            errors++; $display("FAIL midrst_outputs bus %h busy %b run %b totals %h exp all 0",
                               {rd, wr, addr, wdata}, busy, running, totals);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        base = log_q.size();
        tick_to(cyc + 10);
        checks++;
        if (log_q.size() - base !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_quiet got %0d txns busy %b exp 0 0", log_q.size() - base, busy);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_sweep();
        test_stop_mid_sweep();
        test_clean_timeout();
        test_restart_and_early_stop();
        test_saturation();
        test_reset_mid();
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL bus_protocol got %0d violations exp 0", viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
